// File: rtl/evm_pkg.sv
// evm_pkg: shared types and default constants for the EVM ballot session timer.
//   ballot_state_t : session FSM state encoding (IDLE, OPEN, LOCKOUT)
//   SECONDS_W      : width of the seconds_left countdown
//   *_DEF          : default parameter values for a Basys 3 100 MHz build
package evm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OPEN,
      LOCKOUT
   } ballot_state_t;

   localparam int unsigned SECONDS_W         = 8;
   localparam int unsigned TICK_DIV_DEF      = 100_000_000;
   localparam int unsigned VOTE_WINDOW_S_DEF = 30;
   localparam int unsigned LOCKOUT_S_DEF     = 5;
   localparam int unsigned WARN_S_DEF        = 5;

endpackage

// File: rtl/evm_ballot_timer_if.sv
// evm_ballot_timer_if: officer/voter pulses in, session status out.
//   enable_ballot, vote_cast, cancel : single-cycle request pulses (master -> slave)
//   ballot_open, lockout, seconds_left, vote_accepted, timeout_pulse, warn :
//                                      registered session status (slave -> master)
// modport master : button/debouncer side; modport slave : ballot timer.
interface evm_ballot_timer_if;
   import evm_pkg::*;

   logic                 enable_ballot;
   logic                 vote_cast;
   logic                 cancel;
   logic                 ballot_open;
   logic                 lockout;
   logic [SECONDS_W-1:0] seconds_left;
   logic                 vote_accepted;
   logic                 timeout_pulse;
   logic                 warn;

   modport master (
      output enable_ballot, vote_cast, cancel,
      input  ballot_open, lockout, seconds_left, vote_accepted, timeout_pulse, warn
   );

   modport slave (
      input  enable_ballot, vote_cast, cancel,
      output ballot_open, lockout, seconds_left, vote_accepted, timeout_pulse, warn
   );

endinterface

// File: rtl/evm_ballot_timer_tick_prescaler.sv
// tick_prescaler: free-running divider producing a one-cycle tick enable.
//   clk_100MHz : system clock
//   reset      : synchronous active-high reset, count -> 0
//   clear      : synchronous restart of the count at 0
//   tick       : high for the cycle in which count == TICK_DIV-1
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic clk_100MHz,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = $clog2(TICK_DIV);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      tick = (count_q == CNT_W'(TICK_DIV - 1));
   end

   always_comb begin
      count_d = count_q + CNT_W'(1);
      if (clear || tick) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/evm_ballot_timer.sv
// evm_ballot_timer: per-voter ballot session controller (IDLE -> OPEN -> LOCKOUT).
//   clk_100MHz : Basys 3 system clock
//   reset      : synchronous active-high reset; discards any ballot silently
//   bus        : evm_ballot_timer_if.slave (request pulses in, registered status out)
// Optional feature: define EVM_BALLOT_WARN_EN to enable the last-seconds warn
// toggle; otherwise warn is tied low and WARN_S is unused.
module evm_ballot_timer
   import evm_pkg::*;
#(
   parameter int unsigned TICK_DIV      = TICK_DIV_DEF,
   parameter int unsigned VOTE_WINDOW_S = VOTE_WINDOW_S_DEF,
   parameter int unsigned LOCKOUT_S     = LOCKOUT_S_DEF,
   parameter int unsigned WARN_S        = WARN_S_DEF
) (
   input  logic                clk_100MHz,
   input  logic                reset,
   evm_ballot_timer_if.slave   bus
);

   ballot_state_t        state_q, state_d;
   logic [SECONDS_W-1:0] seconds_left_q, seconds_left_d;
   logic                 ballot_open_q, ballot_open_d;
   logic                 lockout_q, lockout_d;
   logic                 vote_accepted_q, vote_accepted_d;
   logic                 timeout_pulse_q, timeout_pulse_d;
   logic                 vote_ev, timeout_ev;
   logic                 tick;
   logic                 state_entry;

   // Restarting the prescaler on every state change makes each phase's
   // first second exactly TICK_DIV cycles long.
   assign state_entry = (state_d != state_q);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .clear      (state_entry),
      .tick       (tick)
   );

   // State and output registers
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state_q         <= IDLE;
         seconds_left_q  <= '0;
         ballot_open_q   <= 1'b0;
         lockout_q       <= 1'b0;
         vote_accepted_q <= 1'b0;
         timeout_pulse_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         seconds_left_q  <= seconds_left_d;
         ballot_open_q   <= ballot_open_d;
         lockout_q       <= lockout_d;
         vote_accepted_q <= vote_accepted_d;
         timeout_pulse_q <= timeout_pulse_d;
      end
   end

   // Next-state logic; OPEN priority is cancel > vote > final tick
   always_comb begin
      state_d    = state_q;
      vote_ev    = 1'b0;
      timeout_ev = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.enable_ballot) state_d = OPEN;
         end
         OPEN: begin
            if (bus.cancel) begin
               state_d = IDLE;
            end else if (bus.vote_cast) begin
               state_d = LOCKOUT;
               vote_ev = 1'b1;
            end else if (tick && seconds_left_q == SECONDS_W'(1)) begin
               state_d    = LOCKOUT;
               timeout_ev = 1'b1;
            end
         end
         LOCKOUT: begin
            if (tick && seconds_left_q == SECONDS_W'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic, registered alongside the state
   always_comb begin
      ballot_open_d   = (state_d == OPEN);
      lockout_d       = (state_d == LOCKOUT);
      vote_accepted_d = vote_ev;
      timeout_pulse_d = timeout_ev;
      seconds_left_d  = seconds_left_q;
      if (state_entry) begin
         unique case (state_d)
            OPEN:    seconds_left_d = SECONDS_W'(VOTE_WINDOW_S);
            LOCKOUT: seconds_left_d = SECONDS_W'(LOCKOUT_S);
            default: seconds_left_d = '0;
         endcase
      end else if (tick && seconds_left_q != '0) begin
         seconds_left_d = seconds_left_q - SECONDS_W'(1);
      end
   end

`ifdef EVM_BALLOT_WARN_EN
   logic warn_q, warn_d;

   // Holds while OPEN, first tick at/below WARN_S sets it, later ticks toggle.
   always_comb begin
      warn_d = (state_d == OPEN) ? warn_q : 1'b0;
      if (state_q == OPEN && state_d == OPEN && tick &&
          seconds_left_d <= SECONDS_W'(WARN_S)) begin
         warn_d = (seconds_left_q > SECONDS_W'(WARN_S)) ? 1'b1 : ~warn_q;
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         warn_q <= 1'b0;
      end else begin
         warn_q <= warn_d;
      end
   end

   assign bus.warn = warn_q;
`else
   assign bus.warn = 1'b0;
`endif

   assign bus.ballot_open   = ballot_open_q;
   assign bus.lockout       = lockout_q;
   assign bus.seconds_left  = seconds_left_q;
   assign bus.vote_accepted = vote_accepted_q;
   assign bus.timeout_pulse = timeout_pulse_q;

endmodule
